wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage MIPS pipeline. It consumes the MEM/WB bundle, selects memory data or ALU result, and extracts and extends loaded bytes or halfwords. It registers the result into the delayed write port that the ID stage's register file consumes. It also exposes that registered write for EX forwarding and keeps retire and misalignment bookkeeping.

## Interface
- Parameters:
- `RETIRE_W`, default 32: width of the retire counter.
- Ports:
- `CLK` in 1: pipeline clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `MEM_WB_read_data` in 32: full aligned memory word read in MEM.
- `MEM_WB_mem_to_reg` in 1: 1 selects the memory path, 0 selects `MEM_WB_address_out`.
- `MEM_WB_reg_write_out` in 1: the instruction writes a register.
- `MEM_WB_address_out` in 32: ALU result / load address.
- `MEM_WB_write_back_destination_out` in 5: destination register.
- `MEM_WB_load_mode` in 2: load width for the memory path.
- `WB_flush` in 1: squash the incoming bundle this cycle.
- `delay_write_register` out 6: register-file write index. Bit 5 is always 0.
- `delay_write_data` out 32: final, already-extended write value.
- `delay_in_RegWrite` out 1: register-file write enable.
- `delay_in_load_mode` out 2: registered load mode, for trace only. The register file must not re-extend.
- `WB_fwd_valid` out 1: equals `delay_in_RegWrite`. Forwarding source for EX.
- `WB_retired` out `RETIRE_W`: count of committed register writes.
- `WB_misalign` out 1: sticky misaligned-load flag.

## Operation
- Load mode encoding:
  - 00: word.
  - 01: halfword, sign-extended.
  - 10: byte, sign-extended.
  - 11: byte, zero-extended.
- Memory is little-endian.
  - Byte lane = `address[1:0]`, bits `[8*lane+7 : 8*lane]`.
  - Halfword lane = `address[1]`, bits `[16*h+15 : 16*h]`.
- Result mux:
  - `mem_to_reg` = 0 → `address_out` passes through unchanged, and `load_mode` is ignored for extraction.
  - `mem_to_reg` = 1 → extract and extend per `load_mode`.
- Commit qualifier: `wen = reg_write_out & ~WB_flush & (dest != 0)`.
  - Writes to $zero are suppressed: `delay_in_RegWrite` = 0.
  - The index and data registers are still loaded.
- Retire counter: increments by 1 on each edge where `wen` = 1. It wraps modulo 2^`RETIRE_W` with no saturation.
- Misalignment: the edge where `mem_to_reg & reg_write_out & ~WB_flush` holds and the access is misaligned sets `WB_misalign`, which stays set until reset.
  - Word access with `addr[1:0]` ≠ 0 is misaligned.
  - Halfword access with `addr[0]` = 1 is misaligned.
  - The load still commits with lane-selected data; the address is not rotated.
- Flush: `WB_flush` = 1 forces `delay_in_RegWrite` to 0 on the next edge. It does not increment the counter or set the misalign flag.

## Timing
- Single register stage. The bundle presented before rising edge N appears on the `delay_*` outputs after edge N; the register file writes at edge N+1.
- Latency is 1 cycle, throughput 1 per cycle. There is no stall input; the stage always accepts.
- `WB_fwd_valid`, `delay_write_register` and `delay_write_data` are stable for the full cycle after edge N.
- Asynchronous reset on `RST_N` low clears every output immediately to 0:
  - `delay_*`, `WB_retired` and `WB_misalign` are all 0.
- Reset deasserts synchronously to `CLK` as seen by the design. The first bundle is captured on the first edge with `RST_N` high.
- Reset asserted mid-stream drops the in-flight write; no partial commit occurs.
- Simultaneous flush and $zero destination: `wen` = 0, with no error.

## Structure
- Shared package `mips_pkg`:
  - Load-mode constants `LM_WORD` = 2'b00, `LM_HALF` = 2'b01, `LM_BYTE` = 2'b10, `LM_BYTEU` = 2'b11.
  - `REG_ZERO` = 5'd0.
  - The MEM/WB bundle struct.
- One combinational sub-module, `load_extender`, takes data, `addr[1:0]` and mode, and returns the extended value plus a misaligned bit.
- Top-level `wb_stage` holds the output registers, the retire counter and the sticky flag.

## Test plan
- Reset: hold `RST_N` = 0 with random inputs → all outputs 0. Release, then present `reg_write` = 1, dest = 8, `mem_to_reg` = 0, `address_out` = 0x1234_5678 → next cycle shows write reg 8, data 0x1234_5678, `RegWrite` = 1, `WB_retired` = 1.
- Byte loads: `read_data` = 0x80FF_7F01, `mem_to_reg` = 1, dest 9.
  - Mode 10 with `addr[1:0]` = 3 → 0xFFFF_FF80.
  - Mode 11 with `addr[1:0]` = 3 → 0x0000_0080.
  - Mode 10 with `addr[1:0]` = 1 → 0x0000_007F.
- Halfword: same word, mode 01.
  - `addr` = 0x…2 → 0xFFFF_80FF.
  - `addr` = 0x…1 → data 0x0000_7F01 (lane 0) and `WB_misalign` = 1, staying 1 afterward.
- $zero and flush:
  - dest = 0 with `reg_write` = 1 → `RegWrite` = 0, counter unchanged.
  - dest = 5 with `WB_flush` = 1 → `RegWrite` = 0, counter unchanged.
- Counter wrap: with `RETIRE_W` = 4, issue 17 valid writes → `WB_retired` = 1.
- Async reset mid-stream: assert `RST_N` low between edges while `RegWrite` = 1 → outputs clear immediately with no write on the following edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: load-mode encoding, register
// constants and the MEM/WB bundle.
package mips_pkg;

  typedef enum logic [1:0] {
    LM_WORD  = 2'b00,
    LM_HALF  = 2'b01,
    LM_BYTE  = 2'b10,
    LM_BYTEU = 2'b11
  } lm_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [31:0] read_data;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] address;
    logic [4:0]  dest;
    lm_t         load_mode;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB bundle in, delayed register-file write port and WB bookkeeping out.
interface wb_stage_if #(
  parameter int RETIRE_W = 32
);
  logic [31:0]         MEM_WB_read_data;
  logic                MEM_WB_mem_to_reg;
  logic                MEM_WB_reg_write_out;
  logic [31:0]         MEM_WB_address_out;
  logic [4:0]          MEM_WB_write_back_destination_out;
  logic [1:0]          MEM_WB_load_mode;
  logic                WB_flush;

  logic [5:0]          delay_write_register;
  logic [31:0]         delay_write_data;
  logic                delay_in_RegWrite;
  logic [1:0]          delay_in_load_mode;
  logic                WB_fwd_valid;
  logic [RETIRE_W-1:0] WB_retired;
  logic                WB_misalign;

  modport master (
    output MEM_WB_read_data, MEM_WB_mem_to_reg, MEM_WB_reg_write_out,
           MEM_WB_address_out, MEM_WB_write_back_destination_out,
           MEM_WB_load_mode, WB_flush,
    input  delay_write_register, delay_write_data, delay_in_RegWrite,
           delay_in_load_mode, WB_fwd_valid, WB_retired, WB_misalign
  );

  modport slave (
    input  MEM_WB_read_data, MEM_WB_mem_to_reg, MEM_WB_reg_write_out,
           MEM_WB_address_out, MEM_WB_write_back_destination_out,
           MEM_WB_load_mode, WB_flush,
    output delay_write_register, delay_write_data, delay_in_RegWrite,
           delay_in_load_mode, WB_fwd_valid, WB_retired, WB_misalign
  );
endinterface

// File: rtl/load_extender.sv
// Little-endian lane extraction and sign/zero extension of a loaded word,
// plus detection of misaligned word/halfword accesses.
module load_extender
  import mips_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  input  lm_t         mode,
  output logic [31:0] result,
  output logic        misaligned
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Halfword lane comes from addr[1] only; addr[0] is flagged, not rotated.
  assign half_sel = addr_lo[1] ? data[31:16] : data[15:0];
  assign byte_sel = data[{addr_lo, 3'b000} +: 8];

  always_comb begin
    result     = data;
    misaligned = 1'b0;
    case (mode)
      LM_WORD: begin
        result     = data;
        misaligned = (addr_lo != 2'b00);
      end
      LM_HALF: begin
        result     = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LM_BYTE:  result = {{24{byte_sel[7]}}, byte_sel};
      LM_BYTEU: result = {24'd0, byte_sel};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU or extended load data, registers the
// register-file write port and tracks retired writes and misaligned loads.
module wb_stage
  import mips_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  wb_stage_if.slave  bus
);

  mem_wb_t             in_b;
  logic [31:0]         ext_data;
  logic                ext_misaligned;
  logic [31:0]         wb_data;
  logic                live;
  logic                wen;

  logic [5:0]          write_register;
  logic [31:0]         write_data;
  logic                reg_write;
  logic [1:0]          load_mode;
  logic [RETIRE_W-1:0] retired;
  logic                misalign;

  assign in_b.read_data  = bus.MEM_WB_read_data;
  assign in_b.mem_to_reg = bus.MEM_WB_mem_to_reg;
  assign in_b.reg_write  = bus.MEM_WB_reg_write_out;
  assign in_b.address    = bus.MEM_WB_address_out;
  assign in_b.dest       = bus.MEM_WB_write_back_destination_out;
  assign in_b.load_mode  = lm_t'(bus.MEM_WB_load_mode);

  load_extender u_load_extender (
    .data       (in_b.read_data),
    .addr_lo    (in_b.address[1:0]),
    .mode       (in_b.load_mode),
    .result     (ext_data),
    .misaligned (ext_misaligned)
  );

  assign wb_data = in_b.mem_to_reg ? ext_data : in_b.address;
  assign live    = in_b.reg_write & ~bus.WB_flush;
  // $zero writes still load index/data but never raise the write enable.
  assign wen     = live & (in_b.dest != REG_ZERO);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      write_register <= '0;
      write_data     <= '0;
      reg_write      <= 1'b0;
      load_mode      <= '0;
      retired        <= '0;
      misalign       <= 1'b0;
    end else begin
      write_register <= {1'b0, in_b.dest};
      write_data     <= wb_data;
      reg_write      <= wen;
      load_mode      <= in_b.load_mode;
      if (wen)
        retired <= retired + 1'b1;
      if (live && in_b.mem_to_reg && ext_misaligned)
        misalign <= 1'b1;
    end
  end

  assign bus.delay_write_register = write_register;
  assign bus.delay_write_data     = write_data;
  assign bus.delay_in_RegWrite    = reg_write;
  assign bus.delay_in_load_mode   = load_mode;
  assign bus.WB_fwd_valid         = reg_write;
  assign bus.WB_retired           = retired;
  assign bus.WB_misalign          = misalign;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a 4-bit retire counter.
module tb_wb_stage;

  localparam int RW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  wb_stage_if #(.RETIRE_W(RW)) bus ();

  wb_stage #(.RETIRE_W(RW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] dest,
                       input logic [31:0] addr, input logic [1:0] mode,
                       input logic flush);
    bus.MEM_WB_reg_write_out              = rw;
    bus.MEM_WB_mem_to_reg                 = m2r;
    bus.MEM_WB_write_back_destination_out = dest;
    bus.MEM_WB_address_out                = addr;
    bus.MEM_WB_load_mode                  = mode;
    bus.WB_flush                          = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg"},    {26'd0, bus.delay_write_register}, 32'd0);
    chk({tag, "_data"},   bus.delay_write_data, 32'd0);
    chk({tag, "_we"},     {31'd0, bus.delay_in_RegWrite}, 32'd0);
    chk({tag, "_lm"},     {30'd0, bus.delay_in_load_mode}, 32'd0);
    chk({tag, "_fwd"},    {31'd0, bus.WB_fwd_valid}, 32'd0);
    chk({tag, "_ret"},    {28'd0, bus.WB_retired}, 32'd0);
    chk({tag, "_mis"},    {31'd0, bus.WB_misalign}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic [5:0] reg_i, input logic [31:0] data,
                        input logic we, input logic [3:0] ret);
    chk({tag, "_reg"},  {26'd0, bus.delay_write_register}, {26'd0, reg_i});
    chk({tag, "_data"}, bus.delay_write_data, data);
    chk({tag, "_we"},   {31'd0, bus.delay_in_RegWrite}, {31'd0, we});
    chk({tag, "_fwd"},  {31'd0, bus.WB_fwd_valid}, {31'd0, we});
    chk({tag, "_ret"},  {28'd0, bus.WB_retired}, {28'd0, ret});
  endtask

  initial begin
    bus.MEM_WB_read_data = $urandom();
    drive(1'b1, 1'b1, 5'd3, $urandom(), 2'b01, 1'b0);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.MEM_WB_read_data = $urandom();
      drive(1'b1, $urandom_range(0, 1) == 1, 5'($urandom_range(1, 31)), $urandom(),
            2'($urandom_range(0, 3)), 1'b0);
      tick();
    end
    chk_all_zero("reset");

    // Release between edges; the next edge captures the first bundle.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 5'd8, 32'h1234_5678, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_wr("alu_pass", 6'd8, 32'h1234_5678, 1'b1, 4'd1);

    bus.MEM_WB_read_data = 32'h80FF_7F01;
    drive(1'b1, 1'b1, 5'd9, 32'h0000_1003, 2'b10, 1'b0);
    tick();
    chk_wr("lb_lane3", 6'd9, 32'hFFFF_FF80, 1'b1, 4'd2);

    drive(1'b1, 1'b1, 5'd9, 32'h0000_1003, 2'b11, 1'b0);
    tick();
    chk_wr("lbu_lane3", 6'd9, 32'h0000_0080, 1'b1, 4'd3);
    chk("lbu_lm", {30'd0, bus.delay_in_load_mode}, 32'd3);

    drive(1'b1, 1'b1, 5'd9, 32'h0000_1001, 2'b10, 1'b0);
    tick();
    chk_wr("lb_lane1", 6'd9, 32'h0000_007F, 1'b1, 4'd4);
    chk("lb_mis", {31'd0, bus.WB_misalign}, 32'd0);

    drive(1'b1, 1'b1, 5'd10, 32'h0000_1004, 2'b00, 1'b0);
    tick();
    chk_wr("lw_aligned", 6'd10, 32'h80FF_7F01, 1'b1, 4'd5);
    chk("lw_mis", {31'd0, bus.WB_misalign}, 32'd0);

    // Flushed misaligned word load: no commit, no sticky flag.
    drive(1'b1, 1'b1, 5'd5, 32'h0000_1001, 2'b00, 1'b1);
    tick();
    chk("flush_mis_we",  {31'd0, bus.delay_in_RegWrite}, 32'd0);
    chk("flush_mis_ret", {28'd0, bus.WB_retired}, 32'd5);
    chk("flush_mis_mis", {31'd0, bus.WB_misalign}, 32'd0);

    drive(1'b1, 1'b1, 5'd11, 32'h0000_1002, 2'b01, 1'b0);
    tick();
    chk_wr("lh_lane1", 6'd11, 32'hFFFF_80FF, 1'b1, 4'd6);
    chk("lh_mis", {31'd0, bus.WB_misalign}, 32'd0);

    drive(1'b1, 1'b1, 5'd11, 32'h0000_1001, 2'b01, 1'b0);
    tick();
    chk_wr("lh_misal", 6'd11, 32'h0000_7F01, 1'b1, 4'd7);
    chk("lh_misal_flag", {31'd0, bus.WB_misalign}, 32'd1);

    drive(1'b1, 1'b0, 5'd0, 32'h0000_AAAA, 2'b00, 1'b0);
    tick();
    chk_wr("zero_dest", 6'd0, 32'h0000_AAAA, 1'b0, 4'd7);
    chk("mis_sticky", {31'd0, bus.WB_misalign}, 32'd1);

    drive(1'b1, 1'b0, 5'd5, 32'h0000_5555, 2'b00, 1'b1);
    tick();
    chk_wr("flush_d5", 6'd5, 32'h0000_5555, 1'b0, 4'd7);

    drive(1'b1, 1'b0, 5'd0, 32'h0000_3333, 2'b00, 1'b1);
    tick();
    chk_wr("flush_zero", 6'd0, 32'h0000_3333, 1'b0, 4'd7);

    drive(1'b1, 1'b0, 5'd12, 32'hCAFE_F00D, 2'b00, 1'b0);
    tick();
    chk_wr("pre_rst", 6'd12, 32'hCAFE_F00D, 1'b1, 4'd8);

    // Asynchronous reset between edges while a write is visible.
    drive(1'b1, 1'b0, 5'd13, 32'hDEAD_BEEF, 2'b00, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_hold");

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 5'd7, 32'h0000_0077, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    chk("wrap16", {28'd0, bus.WB_retired}, 32'd0);
    tick();
    chk("wrap17", {28'd0, bus.WB_retired}, 32'd1);
    chk("wrap17_we", {31'd0, bus.delay_in_RegWrite}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish by 50000");
    $fatal(1, "timeout");
  end

endmodule
